// File: rtl/fclass_seq_if.sv
// fclass_seq_if
//   Request/result handshake bundle for the sequenced FP classify engine.
//   Signals:
//     req_valid / req_ready : request handshake (issue -> engine)
//     Fmt                   : element format, 00 half / 01 single / 10 double / 11 illegal
//     X                     : packed operand
//     res_valid / res_ready : result handshake (engine -> consumer)
//     Res                   : packed 10-bit class masks, one slot per element
//     Illegal               : the request carried an unsupported format
//   Modports: master = requester/consumer side, slave = engine side.
interface fclass_seq_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      Fmt;
  logic [XLEN-1:0] X;
  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] Res;
  logic            Illegal;

  modport master (
    output req_valid, Fmt, X, res_ready,
    input  req_ready, res_valid, Res, Illegal
  );

  modport slave (
    input  req_valid, Fmt, X, res_ready,
    output req_ready, res_valid, Res, Illegal
  );
endinterface

// File: rtl/fclass_seq.sv
// fclass_seq
//   Sequenced floating-point classify engine. Latches one packed operand,
//   classifies one element per cycle through a single shared decoder and
//   accumulates a 10-bit one-hot class mask per element into Res.
//   Ports:
//     clk      : clock, rising edge
//     reset_n  : asynchronous active-low reset
//     Flush    : abort to IDLE, discarding any result (only when
//                FCLASS_SEQ_FLUSH_EN is defined)
//     bus      : fclass_seq_if.slave handshake bundle
//   Parameter XLEN: 32 or 64.
//   Build option: define FCLASS_SEQ_FLUSH_EN to add the Flush input.
//
//   state | meaning
//   IDLE  | waiting for a request, req_ready=1
//   BUSY  | classifying element k, one per cycle
//   DONE  | result held with res_valid=1 until res_ready
module fclass_seq #(
  parameter int XLEN = 64
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef FCLASS_SEQ_FLUSH_EN
  input  logic        Flush,
`endif
  fclass_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] x_q, x_d;
  logic [1:0]      fmt_q, fmt_d;
  logic [1:0]      k_q, k_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            illegal_q, illegal_d;

  logic            flush_w;
  logic            req_ready_w;
  logic            illegal_req;
  logic [1:0]      last_k;

  logic [63:0]     x_ext;
  logic [63:0]     elem;
  logic [5:0]      elem_sh;
  logic            sign;
  logic            exp_zero;
  logic            exp_ones;
  logic            frac_zero;
  logic            frac_msb;
  logic [9:0]      mask;
  logic [5:0]      slot_sh;
  logic [63:0]     mask_placed;

`ifdef FCLASS_SEQ_FLUSH_EN
  assign flush_w = Flush;
`else
  assign flush_w = 1'b0;
`endif

  // Flush blocks acceptance in the same cycle so it always wins.
  assign req_ready_w   = (state_q == ST_IDLE) && !flush_w;
  assign bus.req_ready = req_ready_w;
  assign bus.res_valid = (state_q == ST_DONE);
  assign bus.Res       = res_q;
  assign bus.Illegal   = illegal_q;

  assign illegal_req = (bus.Fmt == 2'b11) || ((bus.Fmt == 2'b10) && (XLEN == 32));

  // Index of the final element for the latched format.
  always_comb begin
    case (fmt_q)
      2'b00:   last_k = 2'(XLEN / 16 - 1);
      2'b01:   last_k = 2'(XLEN / 32 - 1);
      default: last_k = 2'd0;
    endcase
  end

  // Shared element extraction: shift element k down to bit 0.
  assign x_ext = 64'(x_q);

  always_comb begin
    case (fmt_q)
      2'b00:   elem_sh = {k_q, 4'b0000};
      2'b01:   elem_sh = {k_q[0], 5'b00000};
      default: elem_sh = 6'd0;
    endcase
  end

  assign elem = x_ext >> elem_sh;

  always_comb begin
    sign      = 1'b0;
    exp_zero  = 1'b0;
    exp_ones  = 1'b0;
    frac_zero = 1'b0;
    frac_msb  = 1'b0;
    case (fmt_q)
      2'b00: begin
        sign      = elem[15];
        exp_zero  = (elem[14:10] == '0);
        exp_ones  = &elem[14:10];
        frac_zero = (elem[9:0] == '0);
        frac_msb  = elem[9];
      end
      2'b01: begin
        sign      = elem[31];
        exp_zero  = (elem[30:23] == '0);
        exp_ones  = &elem[30:23];
        frac_zero = (elem[22:0] == '0);
        frac_msb  = elem[22];
      end
      default: begin
        sign      = elem[63];
        exp_zero  = (elem[62:52] == '0);
        exp_ones  = &elem[62:52];
        frac_zero = (elem[51:0] == '0);
        frac_msb  = elem[51];
      end
    endcase
  end

  // One-hot class mask; NaN classes ignore the sign.
  always_comb begin
    mask = 10'd0;
    if (exp_ones) begin
      if (frac_zero) mask = sign ? 10'h001 : 10'h080;
      else           mask = frac_msb ? 10'h200 : 10'h100;
    end else if (exp_zero) begin
      if (frac_zero) mask = sign ? 10'h008 : 10'h010;
      else           mask = sign ? 10'h004 : 10'h020;
    end else begin
      mask = sign ? 10'h002 : 10'h040;
    end
  end

  // Slot offset is 10*k, built as 8k + 2k.
  assign slot_sh     = 6'({k_q, 3'b000}) + 6'({k_q, 1'b0});
  assign mask_placed = {54'd0, mask} << slot_sh;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    fmt_d     = fmt_q;
    k_d       = k_q;
    res_d     = res_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_w) begin
          x_d       = bus.X;
          fmt_d     = bus.Fmt;
          k_d       = 2'd0;
          res_d     = '0;
          illegal_d = illegal_req;
          state_d   = illegal_req ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        res_d = res_q | mask_placed[XLEN-1:0];
        if (k_q == last_k) begin
          k_d     = 2'd0;
          state_d = ST_DONE;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      ST_DONE: begin
        if (bus.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_w) begin
      state_d   = ST_IDLE;
      k_d       = 2'd0;
      res_d     = '0;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      fmt_q     <= 2'b00;
      k_q       <= 2'd0;
      res_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      fmt_q     <= fmt_d;
      k_q       <= k_d;
      res_q     <= res_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_fclass_seq.sv
// tb_fclass_seq
//   Self-checking bench for fclass_seq (XLEN=64). Expected results come from
//   an arithmetic classify model of IEEE half/single/double encodings.
//   Define FCLASS_SEQ_FLUSH_EN to also exercise the Flush input.
module tb_fclass_seq;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic reset_n;
`ifdef FCLASS_SEQ_FLUSH_EN
  logic flush;
`endif
  int checks = 0;
  int errors = 0;

  fclass_seq_if #(.XLEN(XLEN)) bus ();

  fclass_seq #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef FCLASS_SEQ_FLUSH_EN
    .Flush   (flush),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int n_elems(input logic [1:0] fmt);
    case (fmt)
      2'b00:   return XLEN / 16;
      2'b01:   return XLEN / 32;
      2'b10:   return (XLEN >= 64) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_illegal(input logic [1:0] fmt);
    return n_elems(fmt) == 0;
  endfunction

  function automatic int exp_bits(input logic [1:0] fmt);
    case (fmt)
      2'b00:   return 5;
      2'b01:   return 8;
      default: return 11;
    endcase
  endfunction

  function automatic logic [63:0] ref_res(input logic [1:0] fmt, input logic [63:0] x);
    longint unsigned r, e, ex, fr, emax;
    int w, ew, fw, cls;
    bit s;
    r = 0;
    if (ref_illegal(fmt)) return 64'd0;
    w  = 16 << fmt;
    ew = exp_bits(fmt);
    fw = w - 1 - ew;
    emax = (64'd1 << ew) - 1;
    for (int i = 0; i < n_elems(fmt); i++) begin
      e = x >> (i * w);
      if (w < 64) e = e & ((64'd1 << w) - 1);
      s  = ((e >> (w - 1)) & 1) != 0;
      ex = (e >> fw) & emax;
      fr = e & ((64'd1 << fw) - 1);
      if (ex == emax)   cls = (fr == 0) ? (s ? 0 : 7) : ((((fr >> (fw - 1)) & 1) != 0) ? 9 : 8);
      else if (ex == 0) cls = (fr == 0) ? (s ? 3 : 4) : (s ? 2 : 5);
      else              cls = s ? 1 : 6;
      r |= 64'd1 << (cls + 10 * i);
    end
    return r;
  endfunction

  // Operand generator biased toward special exponents/fractions.
  function automatic logic [63:0] gen_operand(input logic [1:0] fmt);
    longint unsigned x, ex, fr, e, emax, fmask;
    int w, ew, fw, kind;
    bit s;
    x = {$urandom, $urandom};
    if (ref_illegal(fmt)) return x;
    x = 0;
    w  = 16 << fmt;
    ew = exp_bits(fmt);
    fw = w - 1 - ew;
    emax  = (64'd1 << ew) - 1;
    fmask = (64'd1 << fw) - 1;
    for (int i = 0; i < n_elems(fmt); i++) begin
      kind = $urandom_range(0, 5);
      s    = 1'($urandom_range(0, 1));
      fr   = {$urandom, $urandom} & fmask;
      case (kind)
        0: begin ex = emax; fr = 0; end
        1: begin ex = emax; if (fr == 0) fr = 1; end
        2: begin ex = 0; fr = 0; end
        3: begin ex = 0; if (fr == 0) fr = 1; end
        default: ex = {$urandom, $urandom} & emax;
      endcase
      e = (64'(s) << (w - 1)) | (ex << fw) | fr;
      x |= e << (i * w);
    end
    return x;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic issue(input logic [1:0] fmt, input logic [63:0] x,
                       output int lat, output logic was_ready);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.Fmt = fmt;
    bus.X = x;
    was_ready = bus.req_ready;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.Fmt = 2'($urandom_range(0, 3));
    bus.X = {$urandom, $urandom};
    lat = 0;
    @(negedge clk);
    while (!bus.res_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
    checks++; if (bus.Res !== 64'd0) begin errors++; $display("FAIL reset_res: got %h expected 0", bus.Res); end
    checks++; if (bus.Illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", bus.Illegal); end
    reset_n = 1'b1;
  endtask

  task automatic test_double();
    int lat; logic rdy;
    issue(2'b10, 64'hFFF0000000000000, lat, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL double_accept: req_ready %b expected 1", rdy); end
    checks++; if (lat != 1) begin errors++; $display("FAIL double_latency: got %0d expected 1", lat); end
    checks++; if (bus.Res !== 64'h001) begin errors++; $display("FAIL double_res: got %h expected 001", bus.Res); end
    checks++; if (bus.Illegal !== 1'b0) begin errors++; $display("FAIL double_illegal: got %b expected 0", bus.Illegal); end
    consume();
    checks++; if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL double_release: req_ready %b res_valid %b expected 1 0", bus.req_ready, bus.res_valid); end
  endtask

  task automatic test_singles();
    int lat; logic rdy;
    issue(2'b01, 64'h7FC00000_00000001, lat, rdy);
    checks++; if (lat != 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", lat); end
    checks++; if (bus.Res !== 64'h80020) begin errors++; $display("FAIL single_res: got %h expected 80020", bus.Res); end
    consume();
    checks++; if (bus.Res !== 64'h80020) begin errors++; $display("FAIL single_res_retained: got %h expected 80020", bus.Res); end
  endtask

  task automatic test_halves();
    int lat; logic rdy;
    issue(2'b00, 64'h8000_7C00_FC01_3C00, lat, rdy);
    checks++; if (lat != 4) begin errors++; $display("FAIL half_latency: got %0d expected 4", lat); end
    checks++; if (bus.Res !== 64'h2_0804_0040) begin errors++; $display("FAIL half_res: got %h expected 208040040", bus.Res); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat; logic rdy; logic [63:0] x, exp;
    x = gen_operand(2'b00);
    exp = ref_res(2'b00, x);
    issue(2'b00, x, lat, rdy);
    checks++; if (bus.Res !== exp) begin errors++; $display("FAIL bp_res: got %h expected %h", bus.Res, exp); end
    for (int i = 0; i < 10; i++) begin
      bus.req_valid = 1'b1;
      bus.Fmt = 2'($urandom_range(0, 2));
      bus.X = {$urandom, $urandom};
      @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b1 || bus.Res !== exp || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: res_valid %b Res %h req_ready %b expected 1 %h 0", bus.res_valid, bus.Res, bus.req_ready, exp);
      end
    end
    bus.req_valid = 1'b0;
    consume();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_release: req_ready %b expected 1", bus.req_ready); end
  endtask

  task automatic test_illegal();
    int lat; logic rdy;
    issue(2'b11, {$urandom, $urandom}, lat, rdy);
    checks++; if (lat != 0) begin errors++; $display("FAIL illegal_latency: got %0d expected 0", lat); end
    checks++; if (bus.Res !== 64'd0) begin errors++; $display("FAIL illegal_res: got %h expected 0", bus.Res); end
    checks++; if (bus.Illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b expected 1", bus.Illegal); end
    consume();
    checks++; if (bus.Illegal !== 1'b1 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL illegal_retained: Illegal %b req_ready %b expected 1 1", bus.Illegal, bus.req_ready); end
  endtask

  task automatic test_reset_midbusy();
    int lat; logic rdy; logic [63:0] x;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.Fmt = 2'b00;
    bus.X = gen_operand(2'b00);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL midreset_ctrl: res_valid %b req_ready %b expected 0 1", bus.res_valid, bus.req_ready); end
    checks++; if (bus.Res !== 64'd0 || bus.Illegal !== 1'b0) begin errors++; $display("FAIL midreset_res: Res %h Illegal %b expected 0 0", bus.Res, bus.Illegal); end
    @(negedge clk);
    reset_n = 1'b1;
    x = gen_operand(2'b00);
    issue(2'b00, x, lat, rdy);
    checks++; if (lat != 4 || bus.Res !== ref_res(2'b00, x)) begin errors++; $display("FAIL midreset_next: lat %0d Res %h expected 4 %h", lat, bus.Res, ref_res(2'b00, x)); end
    consume();
  endtask

  task automatic test_random();
    int lat; logic rdy; logic [1:0] fmt; logic [63:0] x, exp;
    for (int n = 0; n < 24; n++) begin
      fmt = 2'($urandom_range(0, 3));
      x = gen_operand(fmt);
      exp = ref_res(fmt, x);
      issue(fmt, x, lat, rdy);
      checks++; if (lat != n_elems(fmt)) begin errors++; $display("FAIL rand_latency[%0d]: fmt %0d got %0d expected %0d", n, fmt, lat, n_elems(fmt)); end
      checks++; if (bus.Res !== exp) begin errors++; $display("FAIL rand_res[%0d]: fmt %0d X %h got %h expected %h", n, fmt, x, bus.Res, exp); end
      checks++; if (bus.Illegal !== ref_illegal(fmt)) begin errors++; $display("FAIL rand_illegal[%0d]: got %b expected %b", n, bus.Illegal, ref_illegal(fmt)); end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    int accepts[$];
    logic [63:0] x, exp;
    x = gen_operand(2'b01);
    exp = ref_res(2'b01, x);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.res_ready = 1'b1;
    bus.Fmt = 2'b01;
    bus.X = x;
    for (int c = 0; c < 60 && accepts.size() < 3; c++) begin
      if (bus.res_valid) begin
        checks++; if (bus.Res !== exp) begin errors++; $display("FAIL b2b_res: got %h expected %h", bus.Res, exp); end
      end
      if (bus.req_valid && bus.req_ready) accepts.push_back(c);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    repeat (6) @(negedge clk);
    bus.res_ready = 1'b0;
    checks++; if (accepts.size() != 3) begin errors++; $display("FAIL b2b_accepts: got %0d expected 3", accepts.size()); end
    for (int i = 1; i < accepts.size(); i++) begin
      checks++; if (accepts[i] - accepts[i-1] != n_elems(2'b01) + 2) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", accepts[i] - accepts[i-1], n_elems(2'b01) + 2); end
    end
    checks++; if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: req_ready %b res_valid %b expected 1 0", bus.req_ready, bus.res_valid); end
  endtask

`ifdef FCLASS_SEQ_FLUSH_EN
  task automatic test_flush();
    int seen;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.Fmt = 2'b00;
    bus.X = gen_operand(2'b00);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_forced: got %b expected 0", bus.req_ready); end
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.Res !== 64'd0) begin errors++; $display("FAIL flush_idle: req_ready %b res_valid %b Res %h expected 1 0 0", bus.req_ready, bus.res_valid, bus.Res); end
    seen = 0;
    repeat (8) begin @(negedge clk); if (bus.res_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_result: res_valid seen %0d expected 0", seen); end
    flush = 1'b1;
    bus.req_valid = 1'b1;
    bus.Fmt = 2'b01;
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL flush_block_ready: got %b expected 0", bus.req_ready); end
    @(posedge clk);
    #1 begin flush = 1'b0; bus.req_valid = 1'b0; end
    seen = 0;
    repeat (6) begin @(negedge clk); if (bus.res_valid || !bus.req_ready) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_not_accepted: busy cycles %0d expected 0", seen); end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
`ifdef FCLASS_SEQ_FLUSH_EN
    flush = 1'b0;
`endif
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.Fmt = 2'b00;
    bus.X = '0;
    test_reset();
    test_double();
    test_singles();
    test_halves();
    test_backpressure();
    test_illegal();
    test_reset_midbusy();
    test_random();
    test_back_to_back();
`ifdef FCLASS_SEQ_FLUSH_EN
    test_flush();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
